// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO, its burst reader and checkers.
package fifo_pkg;

    localparam int WIDTH     = 32;
    localparam int BIT_DEPTH = 4;
    localparam int DEPTH     = 2 ** BIT_DEPTH;

    typedef logic [WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } burst_state_e;

    // Size of a timeout flush burst. A pointer difference of zero on a
    // non-empty FIFO means the FIFO is completely full.
    function automatic int flush_len(input int level, input int depth, input int burst_len);
        int avail;
        avail = (level == 0) ? depth : level;
        return (avail < burst_len) ? avail : burst_len;
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry valid/ready buffer carrying {data, last}. Upstream ready depends
// only on the registered occupancy, so downstream ready never reaches the
// upstream side combinationally. Output fields come straight from the head
// register and stay put while the head is not accepted.
module skid_buf2 #(
    parameter int WIDTH = fifo_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last
);

    logic [WIDTH-1:0] r_head_data;
    logic             r_head_last;
    logic [WIDTH-1:0] r_tail_data;
    logic             r_tail_last;
    logic [1:0]       r_occ;

    logic             w_push;
    logic             w_pop;

    assign o_ready = (r_occ != 2'd2);
    assign o_valid = (r_occ != 2'd0);
    assign o_data  = r_head_data;
    assign o_last  = r_head_last;

    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    // Head/tail storage update; occupancy tracks pushes minus pops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head_data <= '0;
            r_head_last <= 1'b0;
            r_tail_data <= '0;
            r_tail_last <= 1'b0;
            r_occ       <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head_data <= i_data;
                        r_head_last <= i_last;
                    end else begin
                        r_tail_data <= i_data;
                        r_tail_last <= i_last;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    if (r_occ == 2'd2) begin
                        r_head_data <= r_tail_data;
                        r_head_last <= r_tail_last;
                    end
                    r_occ <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Only reachable at occupancy 1: replace the head in place.
                    r_head_data <= i_data;
                    r_head_last <= i_last;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst reader sitting behind the synchronous FIFO. Pops words in bursts of
// up to BURST_LEN beats, either as a full burst when the FIFO reports
// almost_full or as a short flush after TIMEOUT idle cycles, and presents
// them on a valid/ready stream framed by m_last.
// Stream handshake: a beat transfers on a rising clock edge where
// m_valid && m_ready; once m_valid is high, m_data/m_last hold until that
// transfer happens.
module fifo_burst_reader #(
    parameter int WIDTH     = fifo_pkg::WIDTH,
    parameter int BIT_DEPTH = fifo_pkg::BIT_DEPTH,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 empty,
    input  logic                 almost_full,
    input  logic [WIDTH-1:0]     data_out,
    input  logic [BIT_DEPTH-1:0] wr_ptr,
    input  logic [BIT_DEPTH-1:0] rd_ptr,
    output logic                 pop,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_last,
    output logic                 busy
);
    import fifo_pkg::*;

    localparam int DEPTH_N = 2 ** BIT_DEPTH;
    localparam int BLW     = $clog2(BURST_LEN + 1);
    localparam int WCW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    burst_state_e         r_state;
    logic [BLW-1:0]       r_beats_left;
    logic [WCW-1:0]       r_wait_cnt;

    logic [BIT_DEPTH-1:0] w_level;
    logic [BLW-1:0]       w_flush_len;
    logic                 w_skid_ready;
    logic                 w_pop;
    logic                 w_last_tag;
    logic                 w_last_xfer;

    assign w_level     = wr_ptr - rd_ptr;
    assign w_flush_len = BLW'(flush_len(int'({{(32-BIT_DEPTH){1'b0}}, w_level}), DEPTH_N, BURST_LEN));

    // Pop depends only on registered state and the FIFO empty flag.
    assign w_pop       = (r_state == BURST) && !empty && w_skid_ready && (r_beats_left != '0);
    assign w_last_tag  = (r_beats_left == BLW'(1));
    assign w_last_xfer = m_valid && m_ready && m_last;

    assign pop  = w_pop;
    assign busy = (r_state != IDLE);

    // Burst control: trigger selection, beat counting, and drain of the final beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_beats_left <= '0;
            r_wait_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (almost_full) begin
                        r_beats_left <= BLW'(BURST_LEN);
                        r_wait_cnt   <= '0;
                        r_state      <= BURST;
                    end else if (!empty) begin
                        if (r_wait_cnt == WCW'(TIMEOUT)) begin
                            r_beats_left <= w_flush_len;
                            r_wait_cnt   <= '0;
                            r_state      <= BURST;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + WCW'(1);
                        end
                    end else begin
                        r_wait_cnt <= '0;
                    end
                end
                BURST: begin
                    if (w_pop) begin
                        r_beats_left <= r_beats_left - BLW'(1);
                        if (w_last_tag) begin
                            r_state <= DRAIN;
                        end
                    end else if (r_beats_left == '0) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_last_xfer) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    skid_buf2 #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_pop),
        .o_ready (w_skid_ready),
        .i_data  (data_out),
        .i_last  (w_last_tag),
        .o_valid (m_valid),
        .i_ready (m_ready),
        .o_data  (m_data),
        .o_last  (m_last)
    );

    // The FIFO is never read while it reports empty.
    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
        !(pop && empty));

    // A stalled beat keeps its payload until it is accepted.
    a_hold_stalled: assert property (@(posedge clk) disable iff (reset)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_last)));

    // The last beat only leaves while draining, and draining ends on it,
    // so each burst carries exactly one m_last.
    a_last_in_drain: assert property (@(posedge clk) disable iff (reset)
        (m_valid && m_ready && m_last) |-> (r_state == DRAIN));

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO model feeds the reader,
// expected beats are derived from word counts and pushed into exp_q, and a
// negedge monitor compares every accepted beat plus timing/protocol rules.
module tb_fifo_burst_reader;

    localparam int WIDTH     = 32;
    localparam int BIT_DEPTH = 4;
    localparam int BURST_LEN = 8;
    localparam int TIMEOUT   = 15;
    localparam int AF_THR    = 10;
    localparam int W         = WIDTH + 1;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 empty = 1'b1;
    logic                 almost_full = 1'b0;
    logic [WIDTH-1:0]     data_out = '0;
    logic [BIT_DEPTH-1:0] wr_ptr = '0;
    logic [BIT_DEPTH-1:0] rd_ptr = '0;
    logic                 m_ready = 1'b1;
    logic                 pop;
    logic                 m_valid;
    logic [WIDTH-1:0]     m_data;
    logic                 m_last;
    logic                 busy;

    fifo_burst_reader #(
        .WIDTH     (WIDTH),
        .BIT_DEPTH (BIT_DEPTH),
        .BURST_LEN (BURST_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .empty       (empty),
        .almost_full (almost_full),
        .data_out    (data_out),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .pop         (pop),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .busy        (busy)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard storage and counters (counters written by the monitor only)
    logic [W-1:0] exp_q[$];
    int compared   = 0;
    int mismatched = 0;

    // Stimulus-owned state
    logic [WIDTH-1:0]     fifo_q[$];
    logic [BIT_DEPTH-1:0] wr_p = '0;
    logic [BIT_DEPTH-1:0] rd_p = '0;
    int ready_mode = 0;
    int pcnt       = 0;
    int flush_to   = 0;
    int lat_seq    = 0;
    int lat_exp    = 0;
    int to_cnt     = 0;
    bit chk_rst    = 1'b0;
    bit chk_idle   = 1'b0;

    // Monitor-owned state
    int mon_idx     = 0;
    int mon_lat_seq = 0;
    int lat_cnt     = 0;
    int seen_to     = 0;
    int cyc         = 0;
    int first_cyc   = 0;
    int beat_cnt    = 0;
    bit lat_act     = 1'b0;
    bit prev_stall  = 1'b0;
    bit in_burst    = 1'b0;
    bit first_mode0 = 1'b0;
    bit chk_busy_lo = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    logic             prev_last = 1'b0;

    // Monitor: all comparisons happen here, away from the active edge
    always @(negedge clk) begin
        cyc++;
        if (mon_idx < flush_to) mon_idx = flush_to;
        if (to_cnt != seen_to) begin
            seen_to = to_cnt;
            compared++;
            mismatched++;
            $display("FAIL wait_budget: scenario not finished in budget, expired=%0d required=0", to_cnt);
        end
        if (reset) begin
            prev_stall  = 1'b0;
            in_burst    = 1'b0;
            chk_busy_lo = 1'b0;
            lat_act     = 1'b0;
        end else begin
            if (chk_rst) begin
                compared++;
                if (pop || m_valid || busy || m_last || (m_data != '0)) begin
                    mismatched++;
                    $display("FAIL reset_state: pop=%0b m_valid=%0b busy=%0b m_last=%0b m_data=%h, required all 0",
                             pop, m_valid, busy, m_last, m_data);
                end
            end
            if (chk_idle) begin
                compared++;
                if (pop || busy) begin
                    mismatched++;
                    $display("FAIL idle_empty: pop=%0b busy=%0b, required 0 0", pop, busy);
                end
            end
            if (pop) begin
                compared++;
                if (empty) begin
                    mismatched++;
                    $display("FAIL pop_while_empty: pop=1 empty=1, required no pop");
                end
            end
            if (chk_busy_lo) begin
                compared++;
                chk_busy_lo = 1'b0;
                if (busy) begin
                    mismatched++;
                    $display("FAIL busy_drop: busy=1 one cycle after last beat, required 0");
                end
            end
            if (prev_stall) begin
                compared++;
                if (!m_valid || (m_data != prev_data) || (m_last != prev_last)) begin
                    mismatched++;
                    $display("FAIL hold: valid=%0b data=%h last=%0b, required valid=1 data=%h last=%0b",
                             m_valid, m_data, m_last, prev_data, prev_last);
                end
            end
            if (lat_seq != mon_lat_seq) begin
                mon_lat_seq = lat_seq;
                lat_cnt     = 0;
                lat_act     = 1'b1;
            end
            if (lat_act) begin
                lat_cnt++;
                if (pop) begin
                    lat_act = 1'b0;
                    compared++;
                    if (lat_cnt != lat_exp) begin
                        mismatched++;
                        $display("FAIL first_pop_latency: got %0d cycles, required %0d", lat_cnt, lat_exp);
                    end
                end else if (lat_cnt > 400) begin
                    lat_act = 1'b0;
                    compared++;
                    mismatched++;
                    $display("FAIL first_pop_latency: no pop within 400 cycles, required %0d", lat_exp);
                end
            end
            if (m_valid && m_ready) begin
                compared++;
                if (mon_idx >= exp_q.size()) begin
                    mismatched++;
                    $display("FAIL beat_extra: got last=%0b data=%h, required no beat", m_last, m_data);
                end else begin
                    if ({m_last, m_data} != exp_q[mon_idx]) begin
                        mismatched++;
                        $display("FAIL beat[%0d]: got last=%0b data=%h, required last=%0b data=%h",
                                 mon_idx, m_last, m_data, exp_q[mon_idx][W-1], exp_q[mon_idx][WIDTH-1:0]);
                    end
                    mon_idx++;
                end
                if (!in_burst) begin
                    in_burst    = 1'b1;
                    first_cyc   = cyc;
                    beat_cnt    = 0;
                    first_mode0 = (ready_mode == 0);
                end
                beat_cnt++;
                if (m_last) begin
                    in_burst = 1'b0;
                    compared++;
                    if (!busy) begin
                        mismatched++;
                        $display("FAIL busy_on_last: busy=0 during last beat, required 1");
                    end
                    chk_busy_lo = 1'b1;
                    if (first_mode0) begin
                        compared++;
                        if ((cyc - first_cyc) != (beat_cnt - 1)) begin
                            mismatched++;
                            $display("FAIL throughput: %0d beats took %0d cycles, required %0d",
                                     beat_cnt, cyc - first_cyc, beat_cnt - 1);
                        end
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // Present the FIFO model's flags, head word and pointers to the DUT
    task automatic drive_fifo();
        empty       = (fifo_q.size() == 0);
        almost_full = (fifo_q.size() >= AF_THR);
        data_out    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        wr_ptr      = wr_p;
        rd_ptr      = rd_p;
    endtask

    // One clock cycle: sample pop/handshake mid-cycle, apply it after the edge
    task automatic tick(output bit hs);
        bit p;
        @(negedge clk);
        p  = pop && !reset;
        hs = m_valid && m_ready && !reset;
        @(posedge clk);
        #1;
        if (p && (fifo_q.size() != 0)) begin
            void'(fifo_q.pop_front());
            rd_p = rd_p + 1'b1;
        end
        pcnt++;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((pcnt % 3) == 0);
            default: m_ready = ($urandom_range(0, 3) != 0);
        endcase
        drive_fifo();
    endtask

    // Write n words into the idle FIFO and queue the beats they must produce:
    // a count at or above the almost-full mark yields a full burst, anything
    // less is flushed in one burst capped at BURST_LEN.
    task automatic push_words(input int n, input bit seq, input logic [WIDTH-1:0] base);
        logic [WIDTH-1:0] words[$];
        logic [WIDTH-1:0] v;
        int rem;
        int len;
        int k;
        for (int i = 0; i < n; i++) begin
            v = seq ? (base + WIDTH'(i)) : WIDTH'($urandom());
            words.push_back(v);
            fifo_q.push_back(v);
            wr_p = wr_p + 1'b1;
        end
        rem = n;
        k   = 0;
        while (rem > 0) begin
            len = (rem >= AF_THR) ? BURST_LEN : ((rem < BURST_LEN) ? rem : BURST_LEN);
            for (int j = 0; j < len; j++) begin
                exp_q.push_back({(j == len - 1), words[k]});
                k++;
            end
            rem -= len;
        end
        lat_exp = (n >= AF_THR) ? 2 : TIMEOUT + 2;
        lat_seq++;
        drive_fifo();
    endtask

    // Run until every expected beat is out and the reader is idle again
    task automatic wait_done(input int budget);
        bit hs;
        int c;
        c = 0;
        while (!((mon_idx == exp_q.size()) && (fifo_q.size() == 0) && !busy) && (c < budget)) begin
            tick(hs);
            c++;
        end
        if (c >= budget) begin
            to_cnt++;
            reset = 1'b1;
            tick(hs);
            reset = 1'b0;
            fifo_q.delete();
            flush_to = exp_q.size();
            drive_fifo();
        end
        repeat (3) tick(hs);
    endtask

    // Stimulus
    initial begin
        bit hs;
        int n;
        int c;
        drive_fifo();
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b0;
        chk_rst = 1'b1;
        tick(hs);
        chk_rst = 1'b0;

        // Empty FIFO for 100 cycles: nothing may happen
        chk_idle = 1'b1;
        repeat (100) tick(hs);
        chk_idle = 1'b0;

        // Full burst with an always-ready sink, then the 2-word remainder flush
        ready_mode = 0;
        push_words(10, 1'b1, 32'h10);
        wait_done(300);

        // Timeout flush of 3 words
        push_words(3, 1'b1, 32'h100);
        wait_done(300);

        // Backpressure pattern 1,0,0 repeating
        ready_mode = 1;
        pcnt       = 0;
        push_words(10, 1'b1, 32'h10);
        wait_done(600);

        // Pointer wrap: rd=13, wr=2 after five pushes
        ready_mode = 0;
        wr_p = 4'd13;
        rd_p = 4'd13;
        push_words(5, 1'b1, 32'h200);
        wait_done(300);

        // Reset after three beats of a full burst
        push_words(12, 1'b1, 32'h300);
        n = 0;
        c = 0;
        while ((n < 3) && (c < 200)) begin
            tick(hs);
            if (hs) n++;
            c++;
        end
        if (n < 3) to_cnt++;
        reset = 1'b1;
        tick(hs);
        reset = 1'b0;
        fifo_q.delete();
        wr_p     = '0;
        rd_p     = '0;
        flush_to = exp_q.size();
        chk_rst  = 1'b1;
        drive_fifo();
        tick(hs);
        chk_rst = 1'b0;
        repeat (3) tick(hs);
        push_words(3, 1'b1, 32'h400);
        wait_done(300);

        // Randomized scenarios
        repeat (25) begin
            ready_mode = $urandom_range(0, 2);
            n          = $urandom_range(1, 15);
            push_words(n, 1'b0, '0);
            wait_done(800);
        end

        repeat (5) tick(hs);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
